edge_detect_bank: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous or cross-domain level inputs. Each channel has a configurable synchroniser depth, a per-channel mode (off / rising / falling / both), and three outputs: a registered one-cycle event pulse, a sticky status flag and a saturating event counter, each cleared per channel. It sits between raw external inputs and the status/interrupt logic, and replaces single-channel either-edge detection built from discrete flops.

---
 rtl/edge_pkg.sv | 18 +
 rtl/edge_detect_bank_if.sv | 25 ++
 rtl/sync_chain.sv | 29 ++
 rtl/edge_detect_bank.sv | 91 +++++++++
 tb/tb_edge_detect_bank.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared mode encoding and detection helper for the edge detector bank
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic edge_hit(input edge_mode_t m, input logic rise, input logic fall);
    logic [1:0] w_m;
    w_m = m;
    return (rise & w_m[0]) | (fall & w_m[1]);
  endfunction

endpackage

// File: rtl/edge_detect_bank_if.sv
// rtl/edge_detect_bank_if.sv - level inputs, per-channel controls and event outputs of the edge detector bank
interface edge_detect_bank_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);

  logic [CH-1:0]       din;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       pulse;
  logic [CH-1:0]       sticky;
  logic [CH*CNT_W-1:0] cnt;
  logic                any_event;

  modport master (
    output din, mode, clr,
    input  pulse, sticky, cnt, any_event
  );

  modport slave (
    input  din, mode, clr,
    output pulse, sticky, cnt, any_event
  );

endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-bit flop chain bringing asynchronous levels into the clk domain
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/edge_detect_bank.sv
// rtl/edge_detect_bank.sv - per-channel mode-selectable edge detection with pulse, sticky flag and saturating count
import edge_pkg::*;

module edge_detect_bank #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  edge_detect_bank_if.slave bus
);

  localparam int WARM_TOP = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_TOP + 1);

  logic [CH-1:0]     w_sync;
  logic [CH-1:0]     r_hist;
  logic [CH-1:0]     w_rise;
  logic [CH-1:0]     w_fall;
  logic [CH-1:0]     w_det;
  logic [CH-1:0]     w_pulse;
  logic [WARM_W-1:0] r_warm;
  logic              w_armed;

  sync_chain #(
    .WIDTH (CH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(bus.din),
    .o_q(w_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_sync;
    end
  end

  // Hold detection off until the synchroniser and history flops hold real samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm <= '0;
    end else if (!w_armed) begin
      r_warm <= r_warm + 1'b1;
    end
  end

  assign w_armed = (r_warm == WARM_W'(WARM_TOP));
  assign w_rise  = w_sync & ~r_hist;
  assign w_fall  = ~w_sync & r_hist;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_mode_t       w_mode;
    logic             r_pulse;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    assign w_mode   = edge_mode_t'(bus.mode[2*g +: 2]);
    assign w_det[g] = edge_hit(w_mode, w_rise[g], w_fall[g]) & w_armed;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pulse  <= 1'b0;
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_pulse  <= w_det[g];
        // A new event wins over a coincident clear so it is never lost.
        r_sticky <= w_det[g] | (r_sticky & ~bus.clr[g]);
        if (bus.clr[g]) begin
          r_cnt <= w_det[g] ? CNT_W'(1) : '0;
        end else if (w_det[g] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_pulse[g]                    = r_pulse;
    assign bus.sticky[g]                 = r_sticky;
    assign bus.cnt[g*CNT_W +: CNT_W]     = r_cnt;
  end

  assign bus.pulse     = w_pulse;
  assign bus.any_event = |w_pulse;

endmodule

// File: tb/tb_edge_detect_bank.sv
// tb/tb_edge_detect_bank.sv - directed vector bench for edge_detect_bank
module tb_edge_detect_bank;

  typedef struct {
    logic        rst;
    logic [3:0]  din;
    logic [3:0]  clr;
    logic [3:0]  pulse;
    logic [3:0]  sticky;
    logic [15:0] cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  edge_detect_bank_if #(.CH(4), .CNT_W(4)) bus ();

  edge_detect_bank #(
    .CH         (4),
    .SYNC_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] d, input logic [3:0] c,
                     input logic [3:0] p, input logic [3:0] s, input logic [15:0] n);
    vec_t v;
    v.rst = r; v.din = d; v.clr = c; v.pulse = p; v.sticky = s; v.cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n_exp;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.din  = 4'b1111;
    bus.clr  = 4'b0000;
    bus.mode = 8'b00_11_10_01;

    // reset with inputs high, then falls and rises through each mode
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    add(0, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 16'h0110);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 16'h0110);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 16'h0110);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0110, 16'h0110);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0110, 16'h0110);
    add(0, 4'b1111, 4'b0000, 4'b0101, 4'b0111, 16'h0211);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0111, 16'h0211);
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 16'h0000);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      bus.din = vecs[i].din;
      bus.clr = vecs[i].clr;
      tick();
      chk($sformatf("v%0d pulse", i),  32'(bus.pulse),     32'(vecs[i].pulse));
      chk($sformatf("v%0d sticky", i), 32'(bus.sticky),    32'(vecs[i].sticky));
      chk($sformatf("v%0d cnt", i),    32'(bus.cnt),       32'(vecs[i].cnt));
      chk($sformatf("v%0d any", i),    32'(bus.any_event), 32'(|vecs[i].pulse));
    end

    // ch2 saturation: 20 edges, count tops out at 15
    for (int n = 1; n <= 20; n++) begin
      n_exp = (n > 15) ? 15 : n;
      bus.din[2] = ~bus.din[2];
      tick(); chk($sformatf("sat%0d t1 pulse", n), 32'(bus.pulse[2]), 32'd0);
      tick(); chk($sformatf("sat%0d t2 pulse", n), 32'(bus.pulse[2]), 32'd0);
      tick(); chk($sformatf("sat%0d t3 pulse", n), 32'(bus.pulse[2]), 32'd1);
      chk($sformatf("sat%0d any", n), 32'(bus.any_event), 32'd1);
      chk($sformatf("sat%0d cnt", n), 32'(bus.cnt[11:8]), 32'(n_exp));
      tick(); chk($sformatf("sat%0d t4 pulse", n), 32'(bus.pulse[2]), 32'd0);
    end
    chk("sat sticky", 32'(bus.sticky[2]), 32'd1);

    // ch0 rising-only: 14 toggles give 7 events
    for (int n = 0; n < 14; n++) begin
      bus.din[0] = ~bus.din[0];
      repeat (4) tick();
    end
    chk("ch0 cnt7", 32'(bus.cnt[3:0]), 32'd7);
    bus.din[0] = 1'b0;
    repeat (4) tick();
    chk("ch0 fall ignored", 32'(bus.cnt[3:0]), 32'd7);

    // clear on the same edge as a detection
    bus.din[0] = 1'b1;
    tick();
    tick();
    bus.clr[0] = 1'b1;
    tick();
    bus.clr[0] = 1'b0;
    chk("clr+evt pulse", 32'(bus.pulse[0]), 32'd1);
    chk("clr+evt cnt", 32'(bus.cnt[3:0]), 32'd1);
    chk("clr+evt sticky", 32'(bus.sticky[0]), 32'd1);

    // clear alone
    tick();
    chk("pre clr cnt", 32'(bus.cnt[3:0]), 32'd1);
    bus.clr[0] = 1'b1;
    tick();
    bus.clr[0] = 1'b0;
    chk("clr sticky", 32'(bus.sticky[0]), 32'd0);
    chk("clr cnt", 32'(bus.cnt[3:0]), 32'd0);
    tick();
    chk("clr hold cnt", 32'(bus.cnt[3:0]), 32'd0);

    // ch3 edges while off, then enable: nothing fabricated
    bus.din[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("off fall t%0d", i), 32'(bus.pulse[3]), 32'd0);
    end
    bus.din[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("off rise t%0d", i), 32'(bus.pulse[3]), 32'd0);
    end
    bus.mode[7:6] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("enable t%0d", i), 32'(bus.pulse[3]), 32'd0);
    end
    chk("enable sticky", 32'(bus.sticky[3]), 32'd0);
    chk("enable cnt", 32'(bus.cnt[15:12]), 32'd0);

    // mode switched on in the detection cycle takes effect immediately
    bus.din[3] = 1'b0;
    repeat (4) tick();
    bus.mode[7:6] = 2'b00;
    bus.din[3] = 1'b1;
    tick();
    tick();
    bus.mode[7:6] = 2'b01;
    tick();
    chk("same-cycle mode pulse", 32'(bus.pulse[3]), 32'd1);
    chk("same-cycle mode cnt", 32'(bus.cnt[15:12]), 32'd1);
    tick();
    chk("same-cycle mode after", 32'(bus.pulse[3]), 32'd0);

    // reset during activity
    bus.din = 4'b0000;
    tick();
    bus.din = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst pulse", 32'(bus.pulse), 32'd0);
    chk("rst sticky", 32'(bus.sticky), 32'd0);
    chk("rst cnt", 32'(bus.cnt), 32'd0);
    chk("rst any", 32'(bus.any_event), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("post rst t%0d pulse", i), 32'(bus.pulse), 32'd0);
    end
    chk("post rst cnt", 32'(bus.cnt), 32'd0);
    bus.din = 4'b0000;
    tick();
    tick();
    tick();
    chk("rearm pulse", 32'(bus.pulse), 32'b0110);
    chk("rearm cnt", 32'(bus.cnt), 32'h0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
